// File: rtl/dmni_brlite_mon_queue.sv
// dmni_brlite_mon_queue: BrLite monitor sink for the DMNI.
// One FIFO per monitor service. A round-robin engine drains the FIFOs into per-service
// tables in local memory at ptr[ch] + idx * stride.
// Optional build macro DMNI_MON_TIMESTAMP_EN adds tick_i and a second timestamp beat per entry.
module dmni_brlite_mon_queue #(
    parameter int unsigned NSVC   = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned DROP_W = 16,
    localparam int unsigned CH_W  = (NSVC > 1) ? $clog2(NSVC) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mon_req_i,
    output logic                   mon_ack_o,
    input  logic [31:0]            mon_payload_i,
    input  logic [15:0]            mon_seq_source_i,
    input  logic [15:0]            mon_producer_i,
    input  logic [CH_W-1:0]        mon_msvc_i,
`ifdef DMNI_MON_TIMESTAMP_EN
    input  logic [31:0]            tick_i,
`endif
    input  logic                   cfg_we_i,
    input  logic [CH_W-1:0]        cfg_ch_i,
    input  logic [31:0]            cfg_ptr_i,
    input  logic                   clear_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_data_o,
    output logic [NSVC-1:0]        pending_o,
    output logic [NSVC*DROP_W-1:0] drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef DMNI_MON_TIMESTAMP_EN
    localparam int unsigned STRIDE_SH = 3;
`else
    localparam int unsigned STRIDE_SH = 2;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StWrite
`ifdef DMNI_MON_TIMESTAMP_EN
        , StTs
`endif
    } state_e;

    logic [31:0]       ptr_q   [NSVC];
    logic [31:0]       pay_mem [NSVC][DEPTH];
    logic [IDX_W-1:0]  idx_mem [NSVC][DEPTH];
    logic [PTR_W-1:0]  rd_q    [NSVC];
    logic [PTR_W-1:0]  wr_q    [NSVC];
    logic [CNT_W-1:0]  cnt_q   [NSVC];
    logic [DROP_W-1:0] drop_q  [NSVC];
`ifdef DMNI_MON_TIMESTAMP_EN
    logic [31:0]       ts_mem  [NSVC][DEPTH];
    logic [31:0]       ts_q;
    logic [31:0]       head_ts;
`endif

    logic [NSVC-1:0]   push, pop, drop;
    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_q, sel_q, sel_ch, sel_next;
    logic              sel_found;
    logic [31:0]       addr_q, data_q;
    logic [31:0]       head_pay, head_ptr;
    logic [IDX_W-1:0]  head_idx;

    // Ingress: the producer is never stalled, rejected entries are simply lost.
    assign mon_ack_o = mon_req_i;

    // Push/drop decision per channel; full is judged after the same-cycle pop.
    always_comb begin
        push = '0;
        drop = '0;
        for (int c = 0; c < NSVC; c++) begin
            if (mon_req_i && !clear_i && mon_msvc_i == CH_W'(c) && ptr_q[c] != '0) begin
                if (cnt_q[c] != CNT_W'(DEPTH) || pop[c]) push[c] = 1'b1;
                else                                     drop[c] = 1'b1;
            end
        end
    end

    // Round-robin pick: first non-empty channel at or after rr_q.
    always_comb begin
        int unsigned c;
        c         = 0;
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int k = 0; k < NSVC; k++) begin
            c = int'(rr_q) + k;
            if (c >= NSVC) c = c - NSVC;
            if (!sel_found && cnt_q[c] != '0) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(c);
            end
        end
    end

    // Head of the selected FIFO and its table pointer as of pop time.
    always_comb begin
        head_pay = '0;
        head_idx = '0;
        head_ptr = '0;
`ifdef DMNI_MON_TIMESTAMP_EN
        head_ts  = '0;
`endif
        for (int c = 0; c < NSVC; c++) begin
            if (CH_W'(c) == sel_ch) begin
                head_pay = pay_mem[c][rd_q[c]];
                head_idx = idx_mem[c][rd_q[c]];
                head_ptr = ptr_q[c];
`ifdef DMNI_MON_TIMESTAMP_EN
                head_ts  = ts_mem[c][rd_q[c]];
`endif
            end
        end
    end

    // Drain FSM next state and pop strobe; no selection while clearing.
    always_comb begin
        state_d = state_q;
        pop     = '0;
        case (state_q)
            StIdle: begin
                if (!clear_i && sel_found) begin
                    for (int c = 0; c < NSVC; c++) pop[c] = (CH_W'(c) == sel_ch);
                    state_d = StWrite;
                end
            end
            StWrite: begin
`ifdef DMNI_MON_TIMESTAMP_EN
                if (mem_gnt_i) state_d = StTs;
`else
                if (mem_gnt_i) state_d = StIdle;
`endif
            end
`ifdef DMNI_MON_TIMESTAMP_EN
            StTs: begin
                if (mem_gnt_i) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    assign sel_next = (sel_q == CH_W'(NSVC - 1)) ? '0 : sel_q + 1'b1;

    // FSM state, round-robin pointer and the registered memory beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rr_q    <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef DMNI_MON_TIMESTAMP_EN
            ts_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (state_d == StWrite) begin
                        sel_q  <= sel_ch;
                        addr_q <= head_ptr + (32'(head_idx) << STRIDE_SH);
                        data_q <= head_pay;
`ifdef DMNI_MON_TIMESTAMP_EN
                        ts_q   <= head_ts;
`endif
                    end
                end
                StWrite: begin
                    if (mem_gnt_i) begin
`ifdef DMNI_MON_TIMESTAMP_EN
                        addr_q <= addr_q + 32'd4;
                        data_q <= ts_q;
`else
                        rr_q   <= sel_next;
`endif
                    end
                end
`ifdef DMNI_MON_TIMESTAMP_EN
                StTs: begin
                    if (mem_gnt_i) rr_q <= sel_next;
                end
`endif
                default: ;
            endcase
        end
    end

    // Per-channel pointers, FIFO indices/occupancy and saturating drop counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NSVC; c++) begin
                ptr_q[c]  <= '0;
                rd_q[c]   <= '0;
                wr_q[c]   <= '0;
                cnt_q[c]  <= '0;
                drop_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NSVC; c++) begin
                if (cfg_we_i && cfg_ch_i == CH_W'(c)) ptr_q[c] <= cfg_ptr_i;
                if (clear_i) begin
                    rd_q[c]   <= '0;
                    wr_q[c]   <= '0;
                    cnt_q[c]  <= '0;
                    drop_q[c] <= '0;
                end else begin
                    if (push[c]) wr_q[c] <= wr_q[c] + 1'b1;
                    if (pop[c])  rd_q[c] <= rd_q[c] + 1'b1;
                    if (push[c] && !pop[c])      cnt_q[c] <= cnt_q[c] + 1'b1;
                    else if (pop[c] && !push[c]) cnt_q[c] <= cnt_q[c] - 1'b1;
                    if (drop[c] && drop_q[c] != '1) drop_q[c] <= drop_q[c] + 1'b1;
                end
            end
        end
    end

    // FIFO storage, written at the push slot.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NSVC; c++) begin
            if (push[c]) begin
                pay_mem[c][wr_q[c]] <= mon_payload_i;
                idx_mem[c][wr_q[c]] <= mon_producer_i[IDX_W-1:0];
`ifdef DMNI_MON_TIMESTAMP_EN
                ts_mem[c][wr_q[c]]  <= tick_i;
`endif
            end
        end
    end

    // Status outputs.
    always_comb begin
        pending_o  = '0;
        drop_cnt_o = '0;
        for (int c = 0; c < NSVC; c++) begin
            pending_o[c]                   = (cnt_q[c] != '0);
            drop_cnt_o[c*DROP_W +: DROP_W] = drop_q[c];
        end
    end

    assign mem_req_o  = (state_q != StIdle);
    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;

endmodule

// File: tb/tb_dmni_brlite_mon_queue.sv
// tb_dmni_brlite_mon_queue: directed bench for dmni_brlite_mon_queue (NSVC = 3, DEPTH = 4).
// Honours DMNI_MON_TIMESTAMP_EN when defined for both files.
module tb_dmni_brlite_mon_queue;

`ifdef DMNI_MON_TIMESTAMP_EN
    localparam int STRIDE = 8;
    localparam int BEATS  = 2;
`else
    localparam int STRIDE = 4;
    localparam int BEATS  = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mon_req = 1'b0;
    logic        mon_ack;
    logic [31:0] mon_payload = '0;
    logic [15:0] mon_seq_source = '0;
    logic [15:0] mon_producer = '0;
    logic [1:0]  mon_msvc = '0;
    logic [31:0] tick = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [31:0] cfg_ptr = '0;
    logic        clear = 1'b0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  pending;
    logic [47:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] log_addr[$], log_data[$], exp_addr[$], exp_data[$];
    logic [31:0] bases[3];

    dmni_brlite_mon_queue #(
        .NSVC   (3),
        .DEPTH  (4),
        .IDX_W  (8),
        .DROP_W (16)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .mon_req_i        (mon_req),
        .mon_ack_o        (mon_ack),
        .mon_payload_i    (mon_payload),
        .mon_seq_source_i (mon_seq_source),
        .mon_producer_i   (mon_producer),
        .mon_msvc_i       (mon_msvc),
`ifdef DMNI_MON_TIMESTAMP_EN
        .tick_i           (tick),
`endif
        .cfg_we_i         (cfg_we),
        .cfg_ch_i         (cfg_ch),
        .cfg_ptr_i        (cfg_ptr),
        .clear_i          (clear),
        .mem_req_o        (mem_req),
        .mem_gnt_i        (mem_gnt),
        .mem_addr_o       (mem_addr),
        .mem_data_o       (mem_data),
        .pending_o        (pending),
        .drop_cnt_o       (drop_cnt)
    );

    always #5 clk = ~clk;

    // Record every granted beat, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_ni && mem_req && mem_gnt) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [31:0] ptr);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_ptr = ptr;
        step();
        cfg_we  = 1'b0;
    endtask

    task automatic push(input int ch, input logic [15:0] prod, input logic [31:0] pay,
                        input logic [31:0] tk);
        mon_req      = 1'b1;
        mon_msvc     = 2'(ch);
        mon_producer = prod;
        mon_payload  = pay;
        mon_seq_source = prod ^ 16'h5a5a;
        tick         = tk;
        #1;
        chk("ack", 64'(mon_ack), 64'd1);
        step();
        mon_req      = 1'b0;
    endtask

    task automatic expect_entry(input logic [31:0] base, input int idx, input logic [31:0] pay,
                                input logic [31:0] tk);
        exp_addr.push_back(base + 32'(idx * STRIDE));
        exp_data.push_back(pay);
`ifdef DMNI_MON_TIMESTAMP_EN
        exp_addr.push_back(base + 32'(idx * STRIDE) + 32'd4);
        exp_data.push_back(tk);
`endif
    endtask

    task automatic check_log(input string tag);
        int n;
        chk({tag, " beat count"}, 64'(log_addr.size()), 64'(exp_addr.size()));
        n = (log_addr.size() < exp_addr.size()) ? log_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), 64'(log_addr[i]), 64'(exp_addr[i]));
            chk($sformatf("%s data[%0d]", tag, i), 64'(log_data[i]), 64'(exp_data[i]));
        end
        log_addr.delete();
        log_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        bases[0] = 32'h1000;
        bases[1] = 32'h2000;
        bases[2] = 32'h4000;

        // Reset state
        step();
        step();
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst mem_data", 64'(mem_data), 64'd0);
        chk("rst pending", 64'(pending), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst ack", 64'(mon_ack), 64'd0);
        rst_ni = 1'b1;
        step();

        // Basic write with two-cycle latency
        cfg(0, bases[0]);
        cfg(1, bases[1]);
        cfg(2, bases[2]);
        push(0, 16'h0203, 32'hCAFE0001, 32'h11);
        chk("basic pending after push", 64'(pending), 64'b001);
        chk("basic req N+1", 64'(mem_req), 64'd0);
        step();
        chk("basic req N+2", 64'(mem_req), 64'd1);
        chk("basic addr", 64'(mem_addr), 64'(32'h1000 + 32'(3 * STRIDE)));
        chk("basic data", 64'(mem_data), 64'hCAFE0001);
        chk("basic pending popped", 64'(pending), 64'd0);
        expect_entry(32'h1000, 3, 32'hCAFE0001, 32'h11);
        mem_gnt = 1'b1;
        repeat (4) step();
        mem_gnt = 1'b0;
        check_log("basic");

        // Overflow: engine parked on a ch0 beat, six pushes on ch1
        push(0, 16'h0001, 32'hA0000000, 32'h21);
        step();
        for (int i = 0; i < 6; i++)
            push(1, 16'(16'h0010 + i), 32'hB0000000 + 32'(i), 32'h30 + 32'(i));
        chk("ovf drop ch1", 64'(drop_cnt[31:16]), 64'd2);
        chk("ovf drop ch0/ch2", 64'({drop_cnt[47:32], drop_cnt[15:0]}), 64'd0);
        chk("ovf pending", 64'(pending), 64'b010);
        chk("ovf req held", 64'(mem_req), 64'd1);
        chk("ovf addr held", 64'(mem_addr), 64'(32'h1000 + 32'(STRIDE)));
        expect_entry(32'h1000, 1, 32'hA0000000, 32'h21);

        // Push into a full FIFO in the cycle it is popped is accepted
        mem_gnt = 1'b1;
        repeat (BEATS) step();
        mem_gnt = 1'b0;
        push(1, 16'h0020, 32'hB0000006, 32'h36);
        chk("popfull drop ch1", 64'(drop_cnt[31:16]), 64'd2);
        chk("popfull pending", 64'(pending), 64'b010);
        chk("popfull req", 64'(mem_req), 64'd1);
        chk("popfull addr", 64'(mem_addr), 64'(32'h2000 + 32'(16 * STRIDE)));
        chk("popfull data", 64'(mem_data), 64'hB0000000);

        // Clear while a beat waits for grant; a push in the clear cycle is lost
        clear        = 1'b1;
        mon_req      = 1'b1;
        mon_msvc     = 2'd2;
        mon_producer = 16'h0005;
        mon_payload  = 32'hDEAD0000;
        step();
        clear   = 1'b0;
        mon_req = 1'b0;
        chk("clr pending", 64'(pending), 64'd0);
        chk("clr drop_cnt", 64'(drop_cnt), 64'd0);
        chk("clr req kept", 64'(mem_req), 64'd1);
        chk("clr addr kept", 64'(mem_addr), 64'(32'h2000 + 32'(16 * STRIDE)));
        expect_entry(32'h2000, 16'h10, 32'hB0000000, 32'h30);
        mem_gnt = 1'b1;
        repeat (6) step();
        mem_gnt = 1'b0;
        check_log("clear");
        chk("clr idle", 64'(mem_req), 64'd0);
        chk("clr pending after", 64'(pending), 64'd0);

        // Reset mid-operation drops the request without a clock edge
        push(0, 16'h0004, 32'hC0000000, 32'h0);
        step();
        chk("midrst req before", 64'(mem_req), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("midrst req async", 64'(mem_req), 64'd0);
        chk("midrst addr", 64'(mem_addr), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Fairness from rr = 0: two entries per channel
        cfg(0, bases[0]);
        cfg(1, bases[1]);
        cfg(2, bases[2]);
        for (int i = 0; i < 6; i++) begin
            push(i % 3, 16'(i + 1), 32'hF0000000 + 32'(i), 32'h40 + 32'(i));
            expect_entry(bases[i % 3], i + 1, 32'hF0000000 + 32'(i), 32'h40 + 32'(i));
        end
        chk("fair pending", 64'(pending), 64'b111);
        mem_gnt = 1'b1;
        repeat (20) step();
        mem_gnt = 1'b0;
        check_log("fair");

        // Disabled channel and out-of-range service: nothing written, nothing counted
        cfg(0, 32'h0);
        cfg(3, 32'h8000);
        push(0, 16'h0007, 32'h0BAD0000, 32'h0);
        push(3, 16'h0008, 32'h0BAD0001, 32'h0);
        mem_gnt = 1'b1;
        repeat (5) step();
        mem_gnt = 1'b0;
        check_log("invalid");
        chk("invalid drop_cnt", 64'(drop_cnt), 64'd0);
        chk("invalid pending", 64'(pending), 64'd0);
        chk("invalid req", 64'(mem_req), 64'd0);

`ifdef DMNI_MON_TIMESTAMP_EN
        // Timestamp beat follows the payload beat
        cfg(2, 32'h3000);
        push(2, 16'h0002, 32'h12345678, 32'h55);
        exp_addr.push_back(32'h3010);
        exp_data.push_back(32'h12345678);
        exp_addr.push_back(32'h3014);
        exp_data.push_back(32'h55);
        mem_gnt = 1'b1;
        repeat (6) step();
        mem_gnt = 1'b0;
        check_log("ts");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
